scan_code_tx: RTL

//  Device-side PS/2 keyboard emulator: transmits a decimal digit (0-9) as a complete

---
 rtl/scan_code_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/scan_code_tx.sv
// PS/2 device-side keystroke sender: a digit 0-9 goes out as make, F0, make; the device drives ps2_clk.
// Optional KEY_TX_INHIBIT_EN adds i_ps2_clk_in so the host can inhibit; a byte cut short by the host is resent.
module scan_code_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef KEY_TX_INHIBIT_EN
    input  logic       i_ps2_clk_in,
`endif
    input  logic [3:0] i_num,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic       o_ps2_clk,
    output logic       o_ps2_data
);

    localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_BIT_HI, S_BIT_LO, S_GAP, S_ABORT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [HALF_W-1:0]  r_half, w_half_nxt;
    logic [3:0]         r_bit, w_bit_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [1:0]         r_idx, w_idx_nxt;
    logic [7:0]         r_make, w_make_nxt;
    logic               r_ps2_clk, r_ps2_data, r_busy, r_done, r_err;
    logic               w_clk_nxt, w_data_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
    logic               w_accept, w_inh;
    logic [7:0]         w_tx_byte;

    function automatic logic [7:0] make_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'h45;
            4'd1:    c = 8'h16;
            4'd2:    c = 8'h1E;
            4'd3:    c = 8'h26;
            4'd4:    c = 8'h25;
            4'd5:    c = 8'h2E;
            4'd6:    c = 8'h36;
            4'd7:    c = 8'h3D;
            4'd8:    c = 8'h3E;
            4'd9:    c = 8'h46;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Frame bit n: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] n);
        logic v;
        v = 1'b1;
        if (n == 4'd0)
            v = 1'b0;
        else if (n <= 4'd8)
            v = b[3'(n - 4'd1)];
        else if (n == 4'd9)
            v = ~^b;
        return v;
    endfunction

`ifdef KEY_TX_INHIBIT_EN
    logic [1:0] r_inh_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_inh_sync <= 2'b11;
        else
            r_inh_sync <= {r_inh_sync[0], i_ps2_clk_in};
    end
    assign w_inh = ~r_inh_sync[1];
`else
    assign w_inh = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && i_start && (i_num <= 4'd9);

    // State register; line/status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_half     <= '0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_idx      <= '0;
            r_make     <= '0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_half     <= w_half_nxt;
            r_bit      <= w_bit_nxt;
            r_gap      <= w_gap_nxt;
            r_idx      <= w_idx_nxt;
            r_make     <= w_make_nxt;
            r_ps2_clk  <= w_clk_nxt;
            r_ps2_data <= w_data_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_idx_nxt   = r_idx;
        w_make_nxt  = r_make;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                    w_make_nxt  = make_code(i_num);
                    w_idx_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_half_nxt  = '0;
                    w_gap_nxt   = '0;
                end
            end
            S_LOAD: begin
                // An inhibited host parks us at the end of a gap until it lets go.
                if (w_inh) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = GAP_LAST;
                end else begin
                    w_state_nxt = S_BIT_HI;
                end
            end
            S_BIT_HI: begin
                if (w_inh) begin
                    w_state_nxt = S_ABORT;
                    w_half_nxt  = '0;
                    w_bit_nxt   = '0;
                end else if (r_half == HALF_LAST) begin
                    w_state_nxt = S_BIT_LO;
                    w_half_nxt  = '0;
                end else begin
                    w_half_nxt  = r_half + 1'b1;
                end
            end
            S_BIT_LO: begin
                if (r_half == HALF_LAST) begin
                    w_half_nxt = '0;
                    if (r_bit == 4'd10) begin
                        w_bit_nxt = '0;
                        if (r_idx == 2'd2) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = '0;
                            w_idx_nxt   = r_idx + 2'd1;
                        end
                    end else begin
                        w_state_nxt = S_BIT_HI;
                        w_bit_nxt   = r_bit + 4'd1;
                    end
                end else begin
                    w_half_nxt = r_half + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    if (!w_inh) begin
                        w_state_nxt = S_BIT_HI;
                        w_bit_nxt   = '0;
                    end
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            S_ABORT: begin
                if (!w_inh) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_tx_byte = (w_idx_nxt == 2'd1) ? 8'hF0 : w_make_nxt;

    always_comb begin
        w_clk_nxt  = (w_state_nxt != S_BIT_LO);
        w_busy_nxt = !(w_state_nxt inside {S_IDLE, S_LOAD});
        w_done_nxt = (r_state == S_BIT_LO) && (w_state_nxt == S_IDLE);
        w_err_nxt  = (r_state == S_IDLE) && i_start && (i_num > 4'd9);
        w_data_nxt = r_ps2_data;
        // Data only moves as the clock rises, so it is stable through the low half.
        if (w_state_nxt == S_BIT_HI && r_state != S_BIT_HI)
            w_data_nxt = frame_bit(w_tx_byte, w_bit_nxt);
        else if (!(w_state_nxt inside {S_BIT_HI, S_BIT_LO}))
            w_data_nxt = 1'b1;
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_ps2_clk  = r_ps2_clk;
    assign o_ps2_data = r_ps2_data;

endmodule
